// File: rtl/isa_pkg.sv
// Shared ISA types for the issue scoreboard: register classes,
// decoded control bundle, pending-vector type and class helper.
package isa_pkg;

  localparam int NUM_REGS        = 32;
  localparam int REG_IDX_W       = $clog2(NUM_REGS);
  localparam int NUM_REG_CLASSES = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  pend_vec_t;

  typedef enum logic [1:0] {
    CLASS_SCALAR = 2'd0,
    CLASS_FP     = 2'd1,
    CLASS_VEC    = 2'd2
  } reg_class_t;

  typedef struct packed {
    logic       is_valid;
    logic [7:0] opcode;
    logic       uses_rs1;
    reg_class_t rs1_class;
    reg_idx_t   rs1;
    logic       uses_rs2;
    reg_class_t rs2_class;
    reg_idx_t   rs2;
    logic       uses_rd;
    reg_class_t rd_class;
    reg_idx_t   rd;
  } decode_ctrl_t;

  // Maps a bank number onto its register class.
  function automatic reg_class_t cls_of(int c);
    case (c)
      0:       return CLASS_SCALAR;
      1:       return CLASS_FP;
      default: return CLASS_VEC;
    endcase
  endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// One register class's pending vector: one set port, NUM_WB
// writeback clear ports and three read ports (rs1, rs2, rd).
// Ports: i_set/i_set_class/i_set_idx mark a new producer;
//   i_wb_* clear bits of this class; i_rd_idx -> o_rd_hit lookups;
//   o_any = OR of the registered pending bits.
// Macro ISSUE_WB_BYPASS_EN: reads see this cycle's clears.
module scoreboard_bank
  import isa_pkg::*;
#(
  parameter int         NUM_WB = 3,
  parameter reg_class_t CLS    = CLASS_SCALAR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_set,
  input  reg_class_t              i_set_class,
  input  reg_idx_t                i_set_idx,
  input  logic       [NUM_WB-1:0] i_wb_valid,
  input  reg_class_t [NUM_WB-1:0] i_wb_class,
  input  reg_idx_t   [NUM_WB-1:0] i_wb_rd,
  input  reg_idx_t   [2:0]        i_rd_idx,
  output logic       [2:0]        o_rd_hit,
  output logic                    o_any
);

  pend_vec_t r_pend;
  pend_vec_t w_clr;
  pend_vec_t w_set;
  pend_vec_t w_view;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (i_wb_valid[i] && i_wb_class[i] == CLS) begin
        w_clr[i_wb_rd[i]] = 1'b1;
      end
    end
    w_set = '0;
    if (i_set && i_set_class == CLS) begin
      w_set[i_set_idx] = 1'b1;
    end
    // Scalar x0 is hardwired zero and never tracked.
    if (CLS == CLASS_SCALAR) begin
      w_set[0] = 1'b0;
    end
`ifdef ISSUE_WB_BYPASS_EN
    w_view = r_pend & ~w_clr;
`else
    w_view = r_pend;
`endif
    if (CLS == CLASS_SCALAR) begin
      w_view[0] = 1'b0;
    end
  end

  always_comb begin
    o_rd_hit = '0;
    for (int k = 0; k < 3; k++) begin
      o_rd_hit[k] = w_view[i_rd_idx[k]];
    end
  end

  // Set is applied after clear: a new producer in flight wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign o_any = |r_pend;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: RAW/WAW hazard check against per-class pending bits,
// one-entry registered output to execute, writeback clears.
// Ports: in_* decoder handshake, out_* execute handshake, wb_* clears,
//   flush kills output, busy_any/stall_cnt status.
// Macro ISSUE_WB_BYPASS_EN: hazard check sees same-cycle clears.
module issue_scoreboard
  import isa_pkg::*;
#(
  parameter int NUM_WB      = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  decode_ctrl_t                 in_ctrl,
  output logic                         in_ready,
  output logic                         out_valid,
  output decode_ctrl_t                 out_ctrl,
  input  logic                         out_ready,
  input  logic       [NUM_WB-1:0]      wb_valid,
  input  reg_class_t [NUM_WB-1:0]      wb_class,
  input  reg_idx_t   [NUM_WB-1:0]      wb_rd,
  input  logic                         flush,
  output logic                         busy_any,
  output logic       [STALL_CNT_W-1:0] stall_cnt
);

  logic [2:0]                 w_hit [NUM_REG_CLASSES];
  logic [NUM_REG_CLASSES-1:0] w_any;
  reg_idx_t [2:0]             w_rd_idx;
  logic                       w_h1;
  logic                       w_h2;
  logic                       w_h3;
  logic                       w_hazard;
  logic                       w_accept;
  logic                       w_set;
  logic                       w_stall;

  logic                       r_out_valid;
  decode_ctrl_t               r_out_ctrl;
  logic [STALL_CNT_W-1:0]     r_stall;

  assign w_rd_idx = {in_ctrl.rd, in_ctrl.rs2, in_ctrl.rs1};
  assign w_set    = w_accept && in_ctrl.is_valid && in_ctrl.uses_rd;

  for (genvar c = 0; c < NUM_REG_CLASSES; c++) begin : g_bank
    scoreboard_bank #(
      .NUM_WB (NUM_WB),
      .CLS    (cls_of(c))
    ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_set       (w_set),
      .i_set_class (in_ctrl.rd_class),
      .i_set_idx   (in_ctrl.rd),
      .i_wb_valid  (wb_valid),
      .i_wb_class  (wb_class),
      .i_wb_rd     (wb_rd),
      .i_rd_idx    (w_rd_idx),
      .o_rd_hit    (w_hit[c]),
      .o_any       (w_any[c])
    );
  end

  // Route each operand's lookup from the bank of its class.
  always_comb begin
    w_h1 = 1'b0;
    w_h2 = 1'b0;
    w_h3 = 1'b0;
    for (int c = 0; c < NUM_REG_CLASSES; c++) begin
      if (in_ctrl.rs1_class == cls_of(c)) w_h1 = w_hit[c][0];
      if (in_ctrl.rs2_class == cls_of(c)) w_h2 = w_hit[c][1];
      if (in_ctrl.rd_class  == cls_of(c)) w_h3 = w_hit[c][2];
    end
  end

  assign w_hazard = (in_ctrl.uses_rs1 && w_h1)
                 || (in_ctrl.uses_rs2 && w_h2)
                 || (in_ctrl.uses_rd  && w_h3);

  assign in_ready = !flush && !w_hazard
                 && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_stall  = in_valid && w_hazard && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_stall && r_stall != '1) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign busy_any  = |w_any;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized + directed bench for issue_scoreboard with a queue
// scoreboard and a set-based pending-register reference model.
module tb_issue_scoreboard;
  import isa_pkg::*;

  localparam int NUM_WB = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  decode_ctrl_t            in_ctrl;
  logic                    in_ready;
  logic                    out_valid;
  decode_ctrl_t            out_ctrl;
  logic                    out_ready;
  logic       [NUM_WB-1:0] wb_valid;
  reg_class_t [NUM_WB-1:0] wb_class;
  reg_idx_t   [NUM_WB-1:0] wb_rd;
  logic                    flush;
  logic                    busy_any;
  logic [31:0]             stall_cnt;

  issue_scoreboard #(.NUM_WB(NUM_WB), .STALL_CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ctrl   (in_ctrl),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ctrl  (out_ctrl),
    .out_ready (out_ready),
    .wb_valid  (wb_valid),
    .wb_class  (wb_class),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .busy_any  (busy_any),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference state: set of pending (class,reg) pairs, expected
  // contents of the output stage, expected stall count.
  bit           pend [3][NUM_REGS];
  decode_ctrl_t q [$];
  longint       m_stall;
  bit           run = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(int cls, int idx);
    bit b;
    if (cls == 0 && idx == 0) return 0;
    b = pend[cls][idx];
`ifdef ISSUE_WB_BYPASS_EN
    for (int i = 0; i < NUM_WB; i++)
      if (wb_valid[i] && int'(wb_class[i]) == cls && int'(wb_rd[i]) == idx)
        b = 0;
`endif
    return b;
  endfunction

  function automatic bit m_any();
    bit a = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < NUM_REGS; r++) a |= pend[c][r];
    return a;
  endfunction

  // Called right after a negedge with inputs already driven.
  task automatic step();
    bit hz, rdy, acc;
    #1;
    hz = (in_ctrl.uses_rs1 && m_hit(in_ctrl.rs1_class, in_ctrl.rs1))
      || (in_ctrl.uses_rs2 && m_hit(in_ctrl.rs2_class, in_ctrl.rs2))
      || (in_ctrl.uses_rd  && m_hit(in_ctrl.rd_class, in_ctrl.rd));
    rdy = !flush && !hz && (q.size() == 0 || out_ready);
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("busy_any", 64'(busy_any), 64'(m_any()));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    acc = in_valid && rdy;
    @(posedge clk);
    if (!rst_n) begin
      foreach (pend[c, r]) pend[c][r] = 0;
      m_stall = 0;
      q.delete();
    end else begin
      for (int i = 0; i < NUM_WB; i++)
        if (wb_valid[i]) pend[int'(wb_class[i])][int'(wb_rd[i])] = 0;
      if (acc && in_ctrl.is_valid && in_ctrl.uses_rd
          && !(in_ctrl.rd_class == CLASS_SCALAR && in_ctrl.rd == 0))
        pend[int'(in_ctrl.rd_class)][int'(in_ctrl.rd)] = 1;
      if (in_valid && hz && !flush && m_stall != 64'hFFFF_FFFF)
        m_stall++;
      if (acc) q.push_back(in_ctrl);
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic v, input decode_ctrl_t c,
                     input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    step();
    wb_valid = '0;
  endtask

  task automatic set_wb(input int p, input int cls, input int r);
    wb_valid[p] = 1'b1;
    wb_class[p] = reg_class_t'(cls);
    wb_rd[p]    = reg_idx_t'(r);
  endtask

  function automatic decode_ctrl_t mk(bit urd, int rdc, int rd,
                                      bit u1, int c1, int r1,
                                      bit u2 = 0, int c2 = 0, int r2 = 0);
    decode_ctrl_t m = '0;
    m.is_valid  = 1'b1;
    m.opcode    = 8'($urandom);
    m.uses_rd   = urd;
    m.rd_class  = reg_class_t'(rdc);
    m.rd        = reg_idx_t'(rd);
    m.uses_rs1  = u1;
    m.rs1_class = reg_class_t'(c1);
    m.rs1       = reg_idx_t'(r1);
    m.uses_rs2  = u2;
    m.rs2_class = reg_class_t'(c2);
    m.rs2       = reg_idx_t'(r2);
    return m;
  endfunction

  function automatic decode_ctrl_t rnd_ctrl();
    decode_ctrl_t m;
    m = mk($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3));
    m.is_valid = ($urandom_range(0, 9) != 0);
    return m;
  endfunction

  // Monitor: compares the output stage against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (run) begin
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          check("out_ctrl", 64'(out_ctrl), 64'(q[0]));
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  decode_ctrl_t nop, add5, sub5, op;
  longint       s0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    wb_valid  = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      wb_class[i] = CLASS_SCALAR;
      wb_rd[i]    = '0;
    end
    foreach (pend[c, r]) pend[c][r] = 0;
    m_stall = 0;
    nop = mk(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1;
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_busy", 64'(busy_any), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);

    // RAW on scalar x5
    add5 = mk(1, 0, 5, 1, 0, 1);
    sub5 = mk(0, 0, 0, 1, 0, 5);
    cyc(1, add5, 1, 0);
    s0 = m_stall;
    repeat (3) cyc(1, sub5, 1, 0);
    check("raw_stall_cnt", 64'(stall_cnt), 64'(s0 + 3));
    set_wb(0, 0, 5);
    cyc(1, sub5, 1, 0);
    cyc(1, sub5, 1, 0);
    cyc(0, nop, 1, 0);

    // Class separation and vector WAW
    cyc(1, mk(1, 1, 5, 0, 0, 0), 1, 0);
    cyc(1, mk(0, 0, 0, 1, 0, 5), 1, 0);
    cyc(1, mk(1, 2, 5, 0, 0, 0), 1, 0);
    op = mk(1, 2, 5, 1, 0, 2);
    repeat (2) cyc(1, op, 1, 0);
    set_wb(1, 2, 5);
    cyc(1, op, 1, 0);
    cyc(0, nop, 1, 0);
    set_wb(0, 1, 5);
    set_wb(1, 2, 5);
    cyc(0, nop, 1, 0);
    check("cleared_busy", 64'(busy_any), 64'd0);

    // x0 producer/consumer back-to-back, gfx op sets nothing
    cyc(1, mk(1, 0, 0, 1, 0, 3), 1, 0);
    cyc(1, mk(0, 0, 0, 1, 0, 0), 1, 0);
    cyc(1, mk(0, 0, 0, 1, 1, 2, 1, 2, 3), 1, 0);
    cyc(0, nop, 1, 0);
    check("x0_gfx_busy", 64'(busy_any), 64'd0);

    // Backpressure
    cyc(1, mk(0, 0, 0, 0, 0, 0), 1, 0);
    repeat (3) cyc(1, mk(0, 0, 0, 1, 0, 9), 0, 0);
    repeat (3) cyc(1, mk(0, 0, 0, 1, 0, 9), 1, 0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    cyc(0, nop, 1, 0);

    // Set/clear collision on scalar x7
    set_wb(2, 0, 7);
    cyc(1, mk(1, 0, 7, 0, 0, 0), 1, 0);
    check("collide_busy", 64'(busy_any), 64'd1);
    cyc(1, mk(0, 0, 0, 1, 0, 7), 1, 0);
    set_wb(0, 0, 7);
    cyc(0, nop, 1, 0);

    // Flush keeps pending, then reset clears everything
    cyc(1, mk(1, 0, 9, 0, 0, 0), 0, 0);
    cyc(0, nop, 0, 1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_pend", 64'(busy_any), 64'd1);
    rst_n = 1'b0;
    cyc(0, nop, 1, 0);
    rst_n = 1'b1;
    check("reset_busy", 64'(busy_any), 64'd0);
    check("reset_stall", 64'(stall_cnt), 64'd0);

    // Random traffic with one mid-run reset
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_WB; i++)
        if ($urandom_range(0, 2) == 0)
          set_wb(i, $urandom_range(0, 2), $urandom_range(0, 3));
      rst_n = (n != 400);
      cyc($urandom_range(0, 3) != 0, rnd_ctrl(),
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    rst_n = 1'b1;
    cyc(0, nop, 1, 0);
    cyc(0, nop, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue stage directly downstream of the instruction decoder.
- Accepts one `isa_pkg::decode_ctrl_t` per cycle and tracks pending destination registers per operand class (scalar, FP, vector).
- Holds back instructions with RAW or WAW hazards.
- Passes hazard-free instructions to execute through a one-entry registered output stage; writeback ports clear pending bits.

Parameters:
- NUM_WB, 3, number of independent writeback clear ports (scalar ALU, FP/SFU, vector/LSU).
- NUM_REGS, 32, registers per class; index width is `$clog2(NUM_REGS)`, equal to the width of `reg_idx_t`.
- STALL_CNT_W, 32, width of the hazard-stall performance counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decoder holds a decoded instruction
- in_ctrl  input  decode_ctrl_t  decoded control bundle (rs1/rs2/rd, uses_*, *_class)
- in_ready  output  1  instruction accepted this cycle when in_valid && in_ready
- out_valid  output  1  issued instruction present for execute
- out_ctrl  output  decode_ctrl_t  registered copy of accepted in_ctrl
- out_ready  input  1  execute consumes out_ctrl when out_valid && out_ready
- wb_valid  input  NUM_WB  per-port writeback strobe
- wb_class  input  NUM_WB x reg_class_t  class of written register
- wb_rd  input  NUM_WB x reg_idx_t  index of written register
- flush  input  1  pipeline redirect; kill output stage
- busy_any  output  1  any pending bit set in any class
- stall_cnt  output  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pending_scalar/fp/vec all 0.
  - out_valid=0, out_ctrl='0, stall_cnt=0, busy_any=0.
  - Reset mid-operation discards the held instruction and all pending state.
- Hazards are evaluated combinationally on in_ctrl:
  - raw1 = uses_rs1 && pend[rs1_class][rs1]
  - raw2 = uses_rs2 && pend[rs2_class][rs2]
  - waw = uses_rd && pend[rd_class][rd]
  - hazard = raw1 || raw2 || waw
- Scalar register 0 is never pending:
  - No set for scalar rd=0.
  - Scalar rs/rd=0 never causes a hazard.
  - FP and vector register 0 are real registers and are tracked.
- in_ready = !flush && !hazard && (!out_valid || out_ready). It depends combinationally on in_ctrl.
- Accept (in_valid && in_ready):
  - out_ctrl <= in_ctrl; out_valid <= 1 next cycle. Latency is 1 cycle.
  - If uses_rd and not scalar x0, set pend[rd_class][rd].
- Output hold: out_valid && !out_ready holds out_ctrl stable, with no new accept. When out_ready && !accept, out_valid <= 0.
- Writeback: each wb_valid[i] clears pend[wb_class[i]][wb_rd[i]] at the clock edge. Multiple ports targeting the same bit clear it once.
- Simultaneous set (accept) and clear of the same bit: set wins, because the new producer is in flight.
- Flush:
  - out_valid <= 0 and in_ready=0 that cycle.
  - Pending bits are not cleared; in-flight ops still write back.
  - The killed out_ctrl's pending bit stays set until execute writes it back or drops it. Execute always returns a wb for killed ops.
- stall_cnt increments by 1 each cycle with in_valid && hazard && !flush. It saturates at all-ones.
- busy_any = OR of all pending bits (registered state only).
- in_valid with in_ctrl.is_valid=0 is accepted and passed through, with no pending set.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- Defined: the hazard check uses pending bits with this cycle's wb clears already applied. A consumer can issue in the same cycle its producer writes back.
- Undefined: the hazard check uses registered pending bits only, adding one bubble after writeback. This gives a shorter timing path.
- Set-wins priority is identical in both modes.

Decomposition:
- isa_pkg additions:
  - reg_class_t (CLASS_SCALAR, CLASS_FP, CLASS_VEC), already used by decode_ctrl_t.
  - NUM_REG_CLASSES=3 constant.
  - pend_vec_t typedef (logic [NUM_REGS-1:0]).
- One sub-module: scoreboard_bank. Holds one class's pending vector, has set port plus NUM_WB clear ports and 3 read ports.
- issue_scoreboard instantiates three scoreboard_banks plus the handshake/output register.

Test Plan:
- RAW stall: issue ADD with scalar rd=5, then SUB with rs1=5.
  - SUB is stalled (in_ready=0) until wb_valid=1, class SCALAR, rd=5.
  - Bypass build: SUB issues that same cycle. Non-bypass build: SUB issues the next cycle.
  - stall_cnt counts the stall cycles.
- Class separation: FP rd=5 pending; a scalar op reading scalar rs1=5 issues with no stall.
  - A vector op with rd=5 pending in the vector class stalls a following VLD with rd=5 (WAW).
- x0 and gfx: ADD with rd=0 followed by an op reading rs1=0 issues back-to-back.
  - A gfx macro-op (uses_rd=0) sets no bit; busy_any stays 0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and no hazard.
  - in_ready=0 and out_ctrl is unchanged for all 3 cycles.
  - On out_ready=1, one accept per cycle with out_valid held 1.
- Set/clear collision: accept an op with scalar rd=7 in the same cycle as wb clearing scalar 7 → bit 7 set after the edge.
- Flush and reset: flush with out_valid=1 → out_valid=0 next cycle, and the pending bit of rd stays 1. Asserting rst_n=0 then clears busy_any and stall_cnt to 0.
